// File: rtl/multicycle_compare.sv
// Chunk-serial signed/unsigned magnitude comparator with start/done handshake.
// Optional build macro CMP_EARLY_EXIT_EN ends the run at the first differing chunk.
module multicycle_compare #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [2:0]       cond_i,
   input  logic             signed_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             result_o,
   output logic             less_o,
   output logic             equal_o
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       cond_q, cond_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             decided_q, decided_d;
   logic             lessr_q, lessr_d;
   logic             result_q, result_d;
   logic             less_q, less_d;
   logic             equal_q, equal_d;

   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic             chunk_ne, fin_dec, fin_less, finish;

   function automatic logic cond_eval(input logic [2:0] c, input logic lt, input logic eq);
      case (c)
         3'b000:  return lt;
         3'b001:  return ~lt & ~eq;
         3'b010:  return lt | eq;
         3'b011:  return ~lt;
         3'b110:  return eq;
         3'b100:  return ~eq;
         default: return 1'b0;
      endcase
   endfunction

   // Operands shift left each RUN cycle so the chunk under test is always the top one.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cond_d    = cond_q;
      idx_d     = idx_q;
      decided_d = decided_q;
      lessr_d   = lessr_q;
      result_d  = result_q;
      less_d    = less_q;
      equal_d   = equal_q;

      a_chunk  = a_q[WIDTH-1 -: CHUNK];
      b_chunk  = b_q[WIDTH-1 -: CHUNK];
      chunk_ne = (a_chunk != b_chunk);
      fin_dec  = decided_q | chunk_ne;
      fin_less = decided_q ? lessr_q : (a_chunk < b_chunk);
`ifdef CMP_EARLY_EXIT_EN
      finish   = (idx_q == '0) || chunk_ne;
`else
      finish   = (idx_q == '0);
`endif

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               // Flipping the sign bits lets the unsigned chunk compare yield signed order.
               a_d            = src1_i;
               b_d            = src2_i;
               a_d[WIDTH-1]   = src1_i[WIDTH-1] ^ signed_i;
               b_d[WIDTH-1]   = src2_i[WIDTH-1] ^ signed_i;
               cond_d         = cond_i;
               idx_d          = IDX_LAST;
               decided_d      = 1'b0;
               lessr_d        = 1'b0;
               state_d        = S_RUN;
            end
         end
         S_RUN: begin
            a_d       = a_q << CHUNK;
            b_d       = b_q << CHUNK;
            idx_d     = idx_q - 1'b1;
            decided_d = fin_dec;
            lessr_d   = fin_less;
            if (finish) begin
               less_d   = fin_less;
               equal_d  = ~fin_dec;
               result_d = cond_eval(cond_q, fin_less, ~fin_dec);
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         cond_q    <= '0;
         idx_q     <= '0;
         decided_q <= 1'b0;
         lessr_q   <= 1'b0;
         result_q  <= 1'b0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cond_q    <= cond_d;
         idx_q     <= idx_d;
         decided_q <= decided_d;
         lessr_q   <= lessr_d;
         result_q  <= result_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
      end
   end

   assign busy_o   = (state_q == S_RUN);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign less_o   = less_q;
   assign equal_o  = equal_q;

endmodule

// File: tb/tb_multicycle_compare.sv
// Scoreboard bench for multicycle_compare (WIDTH=32, CHUNK=8); honours CMP_EARLY_EXIT_EN.
module tb_multicycle_compare;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] src1_i, src2_i;
   logic [2:0]  cond_i;
   logic        signed_i;
   logic        busy_o, done_o, result_o, less_o, equal_o;

   multicycle_compare #(.WIDTH(32), .CHUNK(8)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .src1_i  (src1_i),
      .src2_i  (src2_i),
      .cond_i  (cond_i),
      .signed_i(signed_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .result_o(result_o),
      .less_o  (less_o),
      .equal_o (equal_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        res;
      logic        lt;
      logic        eq;
      int unsigned lat;
   } exp_t;

   exp_t q[$];
   exp_t prev;
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] c, input logic s);
      exp_t        e;
      logic [31:0] x;
      e.eq = (a == b);
      e.lt = s ? ($signed(a) < $signed(b)) : (a < b);
      case (c)
         3'b000:  e.res = e.lt;
         3'b001:  e.res = !e.lt && !e.eq;
         3'b010:  e.res = e.lt || e.eq;
         3'b011:  e.res = !e.lt;
         3'b110:  e.res = e.eq;
         3'b100:  e.res = !e.eq;
         default: e.res = 1'b0;
      endcase
      e.lat = 4;
`ifdef CMP_EARLY_EXIT_EN
      x = a ^ b;
      if (x[31:24] != 0)      e.lat = 1;
      else if (x[23:16] != 0) e.lat = 2;
      else if (x[15:8] != 0)  e.lat = 3;
`endif
      return e;
   endfunction

   // Drives one request; with hold=1 start_i stays high until the done cycle.
   task automatic run_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, input logic s, input logic hold);
      exp_t        e;
      int unsigned cyc;
      bit          seen;
      q.push_back(model(a, b, c, s));
      @(negedge clk_i);
      src1_i = a; src2_i = b; cond_i = c; signed_i = s; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = hold;
      src1_i  = ~a; src2_i = b ^ 32'h5A5A_A5A5; cond_i = ~c; signed_i = ~s;
      check_val("busy_run", busy_o, 1);
      check_val("res_hold", result_o, prev.res);
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 20) begin
         @(posedge clk_i); #1;
         cyc++;
         seen = done_o;
      end
      start_i = 1'b0;
      e = q.pop_front();
      if (!seen) begin
         check_val("done_timeout", 0, 1);
      end else begin
         check_val("latency", cyc, e.lat);
         check_val("result", result_o, e.res);
         check_val("less", less_o, e.lt);
         check_val("equal", equal_o, e.eq);
         check_val("busy_done", busy_o, 0);
         @(posedge clk_i); #1;
         check_val("done_pulse", done_o, 0);
         check_val("res_after", result_o, e.res);
      end
      prev = e;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned dn;
      logic [31:0] ra, rb;
      logic [2:0]  rc;
      prev = '{res: 1'b0, lt: 1'b0, eq: 1'b0, lat: 0};
      rst_i = 1'b0; start_i = 1'b0; src1_i = '0; src2_i = '0; cond_i = '0; signed_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check_val("rst_busy", busy_o, 0);
      check_val("rst_done", done_o, 0);
      check_val("rst_result", result_o, 0);
      check_val("rst_less", less_o, 0);
      check_val("rst_equal", equal_o, 0);
      @(negedge clk_i); rst_i = 1'b1;

      run_req(32'd5, 32'd7, 3'b000, 1'b0, 1'b0);
      run_req(32'hFFFF_FFFF, 32'd1, 3'b000, 1'b1, 1'b0);
      run_req(32'hFFFF_FFFF, 32'd1, 3'b000, 1'b0, 1'b0);
      run_req(32'h1234_5678, 32'h1234_5678, 3'b110, 1'b0, 1'b0);
      run_req(32'h1234_5678, 32'h1234_5678, 3'b100, 1'b0, 1'b0);
      run_req(32'h1234_5678, 32'h1234_5678, 3'b010, 1'b1, 1'b0);
      run_req(32'h1234_5678, 32'h1234_5678, 3'b001, 1'b0, 1'b0);
      run_req(32'h8000_0000, 32'h7FFF_FFFF, 3'b011, 1'b1, 1'b0);
      run_req(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b1, 1'b0);
      run_req(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1'b0, 1'b0);
      run_req(32'hAB00_0010, 32'hAB00_0001, 3'b001, 1'b0, 1'b0);
      run_req(32'h0000_0001, 32'h0000_0100, 3'b010, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? (ra ^ (32'hFF << (8 * $urandom_range(0, 3)))) : $urandom;
         rc = 3'($urandom_range(0, 7));
         run_req(ra, rb, rc, 1'($urandom_range(0, 1)), 1'b0);
      end

      // Abort mid-run right after a request with result_o=1.
      run_req(32'd3, 32'd9, 3'b000, 1'b0, 1'b0);
      @(negedge clk_i);
      src1_i = 32'd1; src2_i = 32'd2; cond_i = 3'b000; signed_i = 1'b0; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(posedge clk_i); #2;
      rst_i = 1'b0;
      #1;
      check_val("abort_busy", busy_o, 0);
      check_val("abort_done", done_o, 0);
      check_val("abort_result", result_o, 0);
      check_val("abort_less", less_o, 0);
      check_val("abort_equal", equal_o, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i); rst_i = 1'b1;
      dn = 0;
      repeat (8) begin
         @(posedge clk_i); #1;
         if (done_o) dn++;
      end
      check_val("abort_no_done", dn, 0);
      prev = '{res: 1'b0, lt: 1'b0, eq: 1'b0, lat: 0};
      run_req(32'd100, 32'd50, 3'b011, 1'b0, 1'b0);

      // start_i held high through the request while operands change.
      run_req(32'h0000_0010, 32'h0000_0020, 3'b000, 1'b0, 1'b1);
      dn = 0;
      repeat (8) begin
         @(posedge clk_i); #1;
         if (done_o) dn++;
      end
      check_val("hold_no_extra_done", dn, 0);
      check_val("hold_result_kept", result_o, 1);
      check_val("queue_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
